// File: rtl/seq_multiplier.sv
// Radix-2 shift-add 32x32 multiplier. All additions go through a single carry_select_adder.
// Define MUL_SIGNED_EN to honour Op_Signed (magnitude multiply followed by result negation).

module carry_select_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [4:0] blk_c;
   logic [8:0] sum0 [4];
   logic [8:0] sum1 [4];

   // Four 8-bit blocks; upper blocks precompute both carry-in cases and select.
   always_comb begin
      blk_c[0] = cin;
      sum      = '0;
      for (int i = 0; i < 4; i++) begin
         sum0[i]        = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
         sum1[i]        = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + 9'd1;
         sum[8*i +: 8]  = blk_c[i] ? sum1[i][7:0] : sum0[i][7:0];
         blk_c[i+1]     = blk_c[i] ? sum1[i][8]   : sum0[i][8];
      end
      cout = blk_c[4];
   end
endmodule

// state  | meaning
// IDLE   | waiting for operands, In_Ready high
// BUSY   | 32 shift-add steps, then one cycle to pick DONE or NEG_LO
// NEG_LO | Lo = ~Lo + 1, keep carry (signed build only)
// NEG_HI | Hi = ~Hi + carry (signed build only)
// DONE   | product held, Out_Valid high until Out_Ready
module seq_multiplier (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Op_Signed,
   input  logic        In_Valid,
   output logic        In_Ready,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [31:0] Product_Hi,
   output logic [31:0] Product_Lo
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_BUSY   = 3'd1;
   localparam logic [2:0] ST_DONE   = 3'd4;
`ifdef MUL_SIGNED_EN
   localparam logic [2:0] ST_NEG_LO = 3'd2;
   localparam logic [2:0] ST_NEG_HI = 3'd3;
`endif

   logic [2:0]  state;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] m;
   logic [5:0]  count;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_sum;
   logic        add_cin;
   logic        add_cout;
   logic        accept;

`ifdef MUL_SIGNED_EN
   logic carry;
   logic sign_neg;
   logic a_neg;
   logic b_neg;
   assign a_neg = Op_Signed && A[31];
   assign b_neg = Op_Signed && B[31];
`else
   logic op_signed_unused;
   assign op_signed_unused = Op_Signed;
`endif

   assign In_Ready   = (state == ST_IDLE) && !RST;
   assign Out_Valid  = (state == ST_DONE);
   assign accept     = In_Valid && In_Ready;
   assign Product_Hi = hi;
   assign Product_Lo = lo;

   always_comb begin
      add_a   = hi;
      add_b   = lo[0] ? m : '0;
      add_cin = 1'b0;
`ifdef MUL_SIGNED_EN
      case (state)
         ST_IDLE: begin
            add_a   = ~A;
            add_b   = '0;
            add_cin = 1'b1;
         end
         ST_NEG_LO: begin
            add_a   = ~lo;
            add_b   = '0;
            add_cin = 1'b1;
         end
         ST_NEG_HI: begin
            add_a   = ~hi;
            add_b   = '0;
            add_cin = carry;
         end
         default: ;
      endcase
`endif
   end

   carry_select_adder u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         count <= '0;
`ifdef MUL_SIGNED_EN
         carry    <= 1'b0;
         sign_neg <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
`ifdef MUL_SIGNED_EN
                  // The adder is free in IDLE, so it produces |A|. |B| = ~B + 1 is folded in
                  // by loading Lo = ~B and Hi = |A|: Hi's initial value lands as +|A| in the result.
                  m        <= a_neg ? add_sum : A;
                  lo       <= b_neg ? ~B : B;
                  hi       <= b_neg ? (a_neg ? add_sum : A) : '0;
                  sign_neg <= a_neg ^ b_neg;
`else
                  m  <= A;
                  lo <= B;
                  hi <= '0;
`endif
                  count <= '0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (count == 6'd32) begin
`ifdef MUL_SIGNED_EN
                  state <= (sign_neg && ((hi != '0) || (lo != '0))) ? ST_NEG_LO : ST_DONE;
`else
                  state <= ST_DONE;
`endif
               end else begin
                  {hi, lo} <= {add_cout, add_sum, lo[31:1]};
                  count    <= count + 6'd1;
               end
            end
`ifdef MUL_SIGNED_EN
            ST_NEG_LO: begin
               lo    <= add_sum;
               carry <= add_cout;
               state <= ST_NEG_HI;
            end
            ST_NEG_HI: begin
               hi    <= add_sum;
               state <= ST_DONE;
            end
`endif
            ST_DONE: begin
               if (Out_Ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
